// File: rtl/regbus_pkg.sv
// Shared definitions for the register-bus transfer sequencer: datapath
// width, default register count, register indices and the sequencer states.
package regbus_pkg;

  localparam int DW       = 16;
  localparam int NREG_DEF = 8;

  // Bus-attached registers, AC first, then its siblings.
  localparam int REG_AC   = 0;
  localparam int REG_DR   = 1;
  localparam int REG_AR   = 2;
  localparam int REG_PC   = 3;
  localparam int REG_IR   = 4;
  localparam int REG_TR   = 5;
  localparam int REG_OUTR = 6;
  localparam int REG_INPR = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } xfer_state_t;

  // True when a source index addresses an existing register.
  function automatic logic src_in_range(input int unsigned idx, input int unsigned nreg);
    return (idx < nreg);
  endfunction

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// Command, register-bus and response signals of the transfer sequencer.
// master = control unit / register fabric side, slave = the sequencer.
interface reg_xfer_ctrl_if #(
  parameter int NREG = regbus_pkg::NREG_DEF,
  parameter int DW   = regbus_pkg::DW
);

  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [SW-1:0] cmd_src;
  logic          cmd_imm_en;
  logic [DW-1:0] cmd_imm;
  logic [NREG-1:0] cmd_dst;
  logic [NREG-1:0] ldbus;
  logic [DW-1:0] bus_in;
  logic [NREG-1:0] wr;
  logic [DW-1:0] bin;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_src, cmd_imm_en, cmd_imm, cmd_dst, bus_in,
    input  cmd_ready, ldbus, wr, bin, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_imm_en, cmd_imm, cmd_dst, bus_in,
    output cmd_ready, ldbus, wr, bin, rsp_valid, rsp_err, rsp_data
  );

endinterface

// File: rtl/reg_xfer_ctrl_onehot_dec.sv
// Index to one-hot decoder with enable; indices beyond N give all zeros.
module onehot_dec #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  // Set the single bit selected by idx while enabled.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (idx == W'(i))) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer: accepts one command, enables the source
// register onto the bus (or takes an immediate), writes the captured word
// to the destination mask and returns a one-cycle response.
// All bus-side outputs are flops loaded from the next-state values, so the
// command inputs never reach ldbus/wr combinationally.
module reg_xfer_ctrl #(
  parameter int NREG = regbus_pkg::NREG_DEF,
  parameter int DW   = regbus_pkg::DW
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_xfer_ctrl_if.slave bus
);

  import regbus_pkg::*;

  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

  xfer_state_t     state_r, state_s;
  logic [SW-1:0]   src_r, src_s;
  logic [NREG-1:0] dst_r, dst_s;
  logic [DW-1:0]   data_r, data_s;
  logic            err_r, err_s;
  logic            accept_s;
  logic            src_bad_s;
  logic [NREG-1:0] ldbus_dec_s;

  logic [NREG-1:0] ldbus_r;
  logic [NREG-1:0] wr_r;
  logic            cmd_ready_r;
  logic            rsp_valid_r;
  logic            rsp_err_r;
  logic [DW-1:0]   rsp_data_r;

  assign accept_s  = bus.cmd_valid && (state_r == ST_IDLE);
  assign src_bad_s = !src_in_range(32'(bus.cmd_src), NREG);

  // Next-state and command/data latch update.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    data_s  = data_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          src_s = bus.cmd_src;
          dst_s = bus.cmd_dst;
          // Rejection outranks the immediate path.
          if ((bus.cmd_dst == '0) || (!bus.cmd_imm_en && src_bad_s)) begin
            err_s   = 1'b1;
            data_s  = '0;
            state_s = ST_RESP;
          end else if (bus.cmd_imm_en) begin
            err_s   = 1'b0;
            data_s  = bus.cmd_imm;
            state_s = ST_WRITE;
          end else begin
            err_s   = 1'b0;
            data_s  = '0;
            state_s = ST_DRIVE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        data_s  = bus.bus_in;
        state_s = ST_WRITE;
      end
      ST_WRITE: begin
        state_s = ST_RESP;
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  onehot_dec #(
    .N (NREG),
    .W (SW)
  ) u_ldbus_dec (
    .idx    (src_s),
    .en     (state_s == ST_DRIVE),
    .onehot (ldbus_dec_s)
  );

  // State, latches and registered outputs; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      src_r       <= '0;
      dst_r       <= '0;
      data_r      <= '0;
      err_r       <= 1'b0;
      ldbus_r     <= '0;
      wr_r        <= '0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= '0;
    end else begin
      state_r     <= state_s;
      src_r       <= src_s;
      dst_r       <= dst_s;
      data_r      <= data_s;
      err_r       <= err_s;
      ldbus_r     <= ldbus_dec_s;
      wr_r        <= (state_s == ST_WRITE) ? dst_s : '0;
      cmd_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESP);
      rsp_err_r   <= (state_s == ST_RESP) && err_s;
      rsp_data_r  <= ((state_s == ST_RESP) && !err_s) ? data_s : '0;
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.ldbus     = ldbus_r;
  assign bus.wr        = wr_r;
  assign bus.bin       = data_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Scoreboard bench for reg_xfer_ctrl: an 8-register instance and a
// 6-register instance, each with a behavioural register file on its bus.
module tb_reg_xfer_ctrl;

  typedef struct {
    logic        err;
    logic [15:0] data;
    logic [7:0]  ld;
    logic [7:0]  wrm;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_xfer_ctrl_if #(.NREG(8), .DW(16)) if0 ();
  reg_xfer_ctrl_if #(.NREG(6), .DW(16)) if1 ();

  reg_xfer_ctrl #(.NREG(8), .DW(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  reg_xfer_ctrl #(.NREG(6), .DW(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Register files attached to each bus.
  logic [15:0] rf0 [8];
  logic [15:0] rf1 [6];

  always_comb begin
    if0.bus_in = 16'h0000;
    for (int i = 0; i < 8; i++) if (if0.ldbus[i]) if0.bus_in = if0.bus_in | rf0[i];
  end
  always_comb begin
    if1.bus_in = 16'h0000;
    for (int j = 0; j < 6; j++) if (if1.ldbus[j]) if1.bus_in = if1.bus_in | rf1[j];
  end
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (if0.wr[i]) rf0[i] <= if0.bin;
  end
  always @(posedge clk) begin
    for (int j = 0; j < 6; j++) if (if1.wr[j]) rf1[j] <= if1.bin;
  end

  // Reference model state: register contents and pending responses.
  logic [15:0] m0 [8];
  logic [15:0] m1 [6];
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0]  ldacc [2];
  logic [7:0]  wracc [2];
  logic [15:0] binseen [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int s, input logic rv, input logic re, input logic [15:0] rd,
                     input logic [7:0] ld, input logic [7:0] wrv, input logic [15:0] bn);
    exp_t e;
    chk("ldbus_wr_overlap", {31'd0, (|ld) && (|wrv)}, 32'd0);
    chk("ldbus_onehot0", {31'd0, $onehot0(ld)}, 32'd1);
    ldacc[s] = ldacc[s] | ld;
    wracc[s] = wracc[s] | wrv;
    if (|wrv) binseen[s] = bn;
    if (rv) begin
      if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
        chk("unexpected_rsp", {31'd0, rv}, 32'd0);
      end else begin
        if (s == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk("rsp_err", {31'd0, re}, {31'd0, e.err});
        chk("rsp_data", {16'd0, rd}, {16'd0, e.data});
        chk("ldbus_seen", {24'd0, ldacc[s]}, {24'd0, e.ld});
        chk("wr_seen", {24'd0, wracc[s]}, {24'd0, e.wrm});
        if (e.wrm != 8'h00) chk("bin", {16'd0, binseen[s]}, {16'd0, e.data});
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
      ldacc[s] = 8'h00;
      wracc[s] = 8'h00;
    end
  endtask

  // Response monitor: compares every DUT response against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        ldacc[k] = 8'h00;
        wracc[k] = 8'h00;
        binseen[k] = 16'h0000;
      end
    end else begin
      mon(0, if0.rsp_valid, if0.rsp_err, if0.rsp_data, if0.ldbus, if0.wr, if0.bin);
      mon(1, if1.rsp_valid, if1.rsp_err, if1.rsp_data, {2'b00, if1.ldbus}, {2'b00, if1.wr}, if1.bin);
    end
  end

  // Expected outcome of one accepted command, from the transfer rules.
  task automatic model_cmd(input int s, input logic ie, input logic [2:0] src,
                           input logic [15:0] imm, input logic [7:0] dst, input int acc);
    exp_t e;
    int nr;
    logic [7:0] dm;
    nr = (s == 0) ? 8 : 6;
    dm = (s == 0) ? dst : (dst & 8'h3F);
    e.acc = acc;
    if (dm == 8'h00 || (!ie && int'(src) >= nr)) begin
      e.err = 1'b1; e.data = 16'h0000; e.ld = 8'h00; e.wrm = 8'h00; e.lat = 1;
    end else begin
      e.err = 1'b0;
      if (ie) e.data = imm;
      else if (s == 0) e.data = m0[src];
      else e.data = m1[src];
      e.ld  = ie ? 8'h00 : (8'h01 << src);
      e.wrm = dm;
      e.lat = ie ? 2 : 3;
      for (int i = 0; i < nr; i++) begin
        if (dm[i]) begin
          if (s == 0) m0[i] = e.data;
          else m1[i] = e.data;
        end
      end
    end
    if (s == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Present a command, wait (bounded) for acceptance; returns just after the accept edge.
  task automatic send(input int s, input logic ie, input logic [2:0] src, input logic [15:0] imm,
                      input logic [7:0] dst, input bit track, output int acc);
    int n;
    @(negedge clk);
    if (s == 0) begin
      if1.cmd_valid = 1'b0;
      if0.cmd_valid = 1'b1; if0.cmd_imm_en = ie; if0.cmd_src = src;
      if0.cmd_imm = imm; if0.cmd_dst = dst;
    end else begin
      if0.cmd_valid = 1'b0;
      if1.cmd_valid = 1'b1; if1.cmd_imm_en = ie; if1.cmd_src = src;
      if1.cmd_imm = imm; if1.cmd_dst = dst[5:0];
    end
    n = 0;
    while (!((s == 0) ? if0.cmd_ready : if1.cmd_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (n >= 40) chk("accept_timeout", 32'(n), 32'd0);
    else if (track) model_cmd(s, ie, src, imm, dst, acc);
    @(posedge clk);
  endtask

  // Deassert valid and scribble on the command fields, which must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if0.cmd_valid = 1'b0; if1.cmd_valid = 1'b0;
      if0.cmd_src = 3'($urandom); if0.cmd_imm = 16'($urandom); if0.cmd_dst = 8'($urandom);
      if0.cmd_imm_en = 1'($urandom);
      if1.cmd_src = 3'($urandom); if1.cmd_imm = 16'($urandom); if1.cmd_dst = 6'($urandom);
      if1.cmd_imm_en = 1'($urandom);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ready0", {31'd0, if0.cmd_ready}, 32'd1);
    chk("rst_ldbus0", {24'd0, if0.ldbus}, 32'd0);
    chk("rst_wr0", {24'd0, if0.wr}, 32'd0);
    chk("rst_bin0", {16'd0, if0.bin}, 32'd0);
    chk("rst_rspv0", {31'd0, if0.rsp_valid}, 32'd0);
    chk("rst_rspe0", {31'd0, if0.rsp_err}, 32'd0);
    chk("rst_rspd0", {16'd0, if0.rsp_data}, 32'd0);
    chk("rst_ready1", {31'd0, if1.cmd_ready}, 32'd1);
    chk("rst_ldbus1", {26'd0, if1.ldbus}, 32'd0);
    chk("rst_wr1", {26'd0, if1.wr}, 32'd0);
    chk("rst_rspv1", {31'd0, if1.rsp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int a, a1, a2, a3, a4, s;
    logic ie;
    logic [2:0] src;
    logic [7:0] dst;
    if0.cmd_valid = 1'b0; if0.cmd_imm_en = 1'b0; if0.cmd_src = 3'd0; if0.cmd_imm = 16'h0; if0.cmd_dst = 8'h0;
    if1.cmd_valid = 1'b0; if1.cmd_imm_en = 1'b0; if1.cmd_src = 3'd0; if1.cmd_imm = 16'h0; if1.cmd_dst = 6'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset();

    // Preload every register through immediates.
    send(0, 1'b1, 3'd0, 16'h0000, 8'hFF, 1'b1, a);
    send(1, 1'b1, 3'd0, 16'h0000, 8'h3F, 1'b1, a);
    idle(2);
    // Self-transfer of register 2.
    send(0, 1'b1, 3'd0, 16'h00FF, 8'h04, 1'b1, a); idle(1);
    send(0, 1'b0, 3'd2, 16'h0000, 8'h04, 1'b1, a); idle(1);
    // AC to register 2.
    send(0, 1'b1, 3'd0, 16'h1234, 8'h01, 1'b1, a); idle(1);
    send(0, 1'b0, 3'd0, 16'h0000, 8'h04, 1'b1, a); idle(2);
    // Immediate to two destinations.
    send(0, 1'b1, 3'd5, 16'hBEEF, 8'h81, 1'b1, a); idle(2);
    // Error paths.
    send(0, 1'b0, 3'd1, 16'h5555, 8'h00, 1'b1, a); idle(2);
    send(1, 1'b0, 3'd7, 16'h5555, 8'h01, 1'b1, a); idle(2);
    send(1, 1'b0, 3'd6, 16'h5555, 8'h02, 1'b1, a); idle(1);
    send(1, 1'b1, 3'd7, 16'hCAFE, 8'h20, 1'b1, a); idle(1);
    send(1, 1'b0, 3'd5, 16'h0000, 8'h01, 1'b1, a); idle(2);

    // Back-to-back with valid held: register, immediate, error, immediate.
    send(0, 1'b0, 3'd0, 16'h0000, 8'h10, 1'b1, a1);
    send(0, 1'b1, 3'd0, 16'hA5A5, 8'h08, 1'b1, a2);
    send(0, 1'b1, 3'd0, 16'h1111, 8'h00, 1'b1, a3);
    send(0, 1'b1, 3'd0, 16'h2222, 8'h02, 1'b1, a4);
    idle(4);
    chk("spacing_reg", 32'(a2 - a1), 32'd4);
    chk("spacing_imm", 32'(a3 - a2), 32'd3);
    chk("spacing_err", 32'(a4 - a3), 32'd2);

    // Reset pulse in the WRITE cycle drops the command.
    send(0, 1'b0, 3'd3, 16'h0000, 8'h20, 1'b0, a);
    @(negedge clk); if0.cmd_valid = 1'b0;
    @(posedge clk); #2;
    chk("wr_in_write", {24'd0, if0.wr}, 32'h20);
    rst_n = 1'b0;
    #1;
    chk("wr_async_clear", {24'd0, if0.wr}, 32'd0);
    chk("ldbus_async_clear", {24'd0, if0.ldbus}, 32'd0);
    chk("rspv_async_clear", {31'd0, if0.rsp_valid}, 32'd0);
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, if0.cmd_ready}, 32'd1);
    repeat (4) @(negedge clk);
    send(0, 1'b0, 3'd3, 16'h0000, 8'h40, 1'b1, a); idle(3);
    send(0, 1'b0, 3'd5, 16'h0000, 8'h01, 1'b1, a); idle(3);

    // Randomized traffic on both instances.
    for (int k = 0; k < 80; k++) begin
      s   = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ie  = 1'($urandom_range(0, 1));
      src = 3'($urandom_range(0, 7));
      dst = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      send(s, ie, src, 16'($urandom), dst, 1'b1, a);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(10);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_xfer_ctrl.md
# reg_xfer_ctrl

Register-transfer sequencer: the bus-side initiator that drives the `LDBUS`/`WR` controls of the 16-bit datapath registers (AC and siblings).

- Accepts one transfer command at a time over a valid/ready handshake.
- Runs a two-cycle bus sequence:
  - DRIVE: one-hot enable the source register onto the bus and capture the bus value.
  - WRITE: present the captured word on the register write bus and pulse the destination write enables.
- Reports completion or error on a one-cycle response strobe.
- Sits between the control unit and the register file/bus fabric.

## Interface

Parameters:
- `NREG`, 8: number of bus-attached registers; source index width is `$clog2(NREG)`.
- `DW`, 16: datapath width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_src`  in  `$clog2(NREG)`  source register index.
- `cmd_imm_en`  in  1  source is `cmd_imm` instead of a register.
- `cmd_imm`  in  DW  immediate source word.
- `cmd_dst`  in  NREG  destination write mask; multiple bits allowed.
- `ldbus`  out  NREG  one-hot source enables to the registers' `LDBUS`.
- `bus_in`  in  DW  resolved bus value driven by the enabled register.
- `wr`  out  NREG  destination write enables to the registers' `WR`.
- `bin`  out  DW  write data to the registers' `BIN`.
- `rsp_valid`  out  1  one-cycle completion strobe.
- `rsp_err`  out  1  qualifies `rsp_valid`; 1 = command rejected.
- `rsp_data`  out  DW  word transferred; valid with `rsp_valid`.

## Operation

- States: IDLE, DRIVE, WRITE, RESP.
- **IDLE:** `cmd_ready`=1. Acceptance happens when `cmd_valid && cmd_ready` at a rising edge; the controller latches `cmd_src`, `cmd_imm_en`, `cmd_imm` and `cmd_dst`. Next state:
  - DRIVE if the command is a register source with `cmd_src < NREG`.
  - WRITE if `cmd_imm_en`=1; the immediate goes straight into the data latch.
  - RESP with error if `cmd_dst`==0, or if `cmd_imm_en`=0 and `cmd_src >= NREG`.
  - Error takes priority over the immediate path.
- **DRIVE:** `ldbus[src]`=1, all other `ldbus` bits 0. At the end-of-cycle edge the controller captures `bus_in` into the data latch, then goes to WRITE.
- **WRITE:** `wr` = latched `cmd_dst`; `bin` = data latch. Registers write on the end-of-cycle edge. Next state is RESP.
- **RESP:** `rsp_valid`=1 for exactly one cycle. `rsp_data` = data latch; it is 0 on error. `rsp_err` is set as decided above. Next state is IDLE.
- `ldbus` and `wr` are never asserted in the same cycle.
- At most one `ldbus` bit is set in any cycle.
- Self-transfer (`cmd_dst` includes `cmd_src`) is legal; the register rewrites its own value.
- `cmd_*` inputs are ignored outside the accepting edge.
- Outputs are registered from state and latches; there is no combinational path from `cmd_*` to `ldbus`/`wr`.
- Reset mid-transfer:
  - Immediately clears `ldbus`, `wr`, `rsp_valid` and `rsp_err`.
  - Returns to IDLE; the in-flight command is dropped with no response.

## Timing

- Reset values:
  - state = IDLE; `cmd_ready`=1.
  - `ldbus`=0, `wr`=0, `bin`=0.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0.
- Register source: accept edge T0. DRIVE cycle T0→T1 (capture at T1). WRITE cycle T1→T2. `rsp_valid` high T2→T3. Throughput is one command per 4 cycles.
- Immediate source: accept T0, WRITE T0→T1, `rsp_valid` T1→T2. Throughput is one command per 3 cycles.
- Error: accept T0, `rsp_valid`+`rsp_err` T0→T1. Throughput is one command per 2 cycles.
- `cmd_ready` is 1 only in IDLE; it deasserts the cycle after acceptance and reasserts the cycle after RESP.
- `bus_in` must be stable before the rising edge that ends DRIVE.

## Structure

- Shared package `regbus_pkg` holds:
  - the state enum `xfer_state_t`;
  - `DW`;
  - the default `NREG`;
  - the register index localparams (AC=0, then the sibling registers).
- One sub-module, `onehot_dec`: index → one-hot NREG vector with an enable input. It is used for `ldbus`.
- The FSM and latches stay in the top module.

## Test plan

- Reset, then src=0 (AC holds 16'h1234), dst=8'b0000_0100:
  - `ldbus`=8'h01 for one cycle;
  - then `wr`=8'h04 with `bin`=16'h1234;
  - then `rsp_valid` with `rsp_data`=16'h1234, `rsp_err`=0;
  - 4 cycles total.
- Immediate 16'hBEEF, dst=8'b1000_0001: `ldbus` stays 0; `wr`=8'h81 with `bin`=16'hBEEF on the cycle after acceptance; response 1 cycle later.
- Error paths, each giving a single-cycle `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0, with `ldbus`/`wr` never asserted:
  - dst=0;
  - NREG=6 with src=7.
- Back-to-back `cmd_valid` held high with three commands: `cmd_ready` drops after each acceptance; commands complete in order with 4-, 3- and 2-cycle spacing as per type; no overlap of `ldbus`/`wr`.
- `rst_n` pulsed low during the WRITE cycle: `wr` goes to 0 asynchronously; no `rsp_valid`; `cmd_ready`=1 after release; the next command completes normally.
- Self-transfer src=2 (value 16'h00FF), dst=8'h04: `rsp_data`=16'h00FF and `bin`=16'h00FF during WRITE.
